// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and the operand bundle handed from operand fetch to execute.
package operand_fetch_stage_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int PC_W  = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    reg_idx_t        rd;
    logic            rd_we;
    logic [PC_W-1:0] pc;
  } bundle_t;

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Pending-write bit per architectural register; set on issue, cleared by writeback or flush.
// Combinational lookups for three addresses; a same-cycle set beats any clear.
module reg_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_rd,
  input  logic     clr_en,
  input  reg_idx_t clr_rd,
  input  logic     fl_en,
  input  reg_idx_t fl_rd,
  input  reg_idx_t rd_a1,
  input  reg_idx_t rd_a2,
  input  reg_idx_t rd_a3,
  output logic     pend_a1,
  output logic     pend_a2,
  output logic     pend_a3
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_rd] = 1'b0;
    if (fl_en)  pend_d[fl_rd]  = 1'b0;
    if (set_en) pend_d[set_rd] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend_a1 = pend_q[rd_a1];
  assign pend_a2 = pend_q[rd_a2];
  assign pend_a3 = pend_q[rd_a3];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RAW/WAW stall via scoreboard, registered bundle out, 1-cycle latency, holds until out_ready.
// BYPASS_EN enables writeback-to-operand forwarding and lets a reader issue in the writeback cycle.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [PC_W-1:0] in_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [PC_W-1:0] out_pc
);

  logic    out_valid_q, out_valid_d;
  bundle_t bundle_q, bundle_d;
  logic    pend_rs1, pend_rs2, pend_rd;
  logic    haz_rs1, haz_rs2, haz_waw;
  logic    accept;
  logic [XLEN-1:0] op1, op2;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept & in_rd_we & (in_rd != ZERO_REG)),
    .set_rd  (in_rd),
    .clr_en  (wb_valid),
    .clr_rd  (wb_rd),
    .fl_en   (flush & out_valid_q & bundle_q.rd_we),
    .fl_rd   (bundle_q.rd),
    .rd_a1   (in_rs1),
    .rd_a2   (in_rs2),
    .rd_a3   (in_rd),
    .pend_a1 (pend_rs1),
    .pend_a2 (pend_rs2),
    .pend_a3 (pend_rd)
  );

`ifdef BYPASS_EN
  // A writeback landing this cycle resolves the hazard; its data is forwarded.
  logic byp_rs1, byp_rs2, byp_rd;
  assign byp_rs1 = wb_valid & (wb_rd == in_rs1);
  assign byp_rs2 = wb_valid & (wb_rd == in_rs2);
  assign byp_rd  = wb_valid & (wb_rd == in_rd);
  assign haz_rs1 = (in_rs1 != ZERO_REG) & pend_rs1 & ~byp_rs1;
  assign haz_rs2 = (in_rs2 != ZERO_REG) & pend_rs2 & ~byp_rs2;
  assign haz_waw = in_rd_we & pend_rd & ~byp_rd;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign haz_rs1 = (in_rs1 != ZERO_REG) & pend_rs1;
  assign haz_rs2 = (in_rs2 != ZERO_REG) & pend_rs2;
  assign haz_waw = in_rd_we & pend_rd;
`endif

  assign in_ready = ~flush & ~(haz_rs1 | haz_rs2 | haz_waw) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (in_rs1 != ZERO_REG) begin
`ifdef BYPASS_EN
      op1 = byp_rs1 ? wb_data : rf_rd1;
`else
      op1 = rf_rd1;
`endif
    end
    if (in_rs2 != ZERO_REG) begin
`ifdef BYPASS_EN
      op2 = byp_rs2 ? wb_data : rf_rd2;
`else
      op2 = rf_rd2;
`endif
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d    = 1'b1;
      bundle_d.op1   = op1;
      bundle_d.op2   = op2;
      bundle_d.rd    = in_rd;
      bundle_d.rd_we = in_rd_we;
      bundle_d.pc    = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = bundle_q.op1;
  assign out_op2   = bundle_q.op2;
  assign out_rd    = bundle_q.rd;
  assign out_rd_we = bundle_q.rd_we;
  assign out_pc    = bundle_q.pc;

endmodule
